token_rr_arbiter: RTL

TOKEN_RR_ARBITER -- requirements
Module: token_rr_arbiter

---
 rtl/token_rr_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/token_rr_arbiter.sv
// token_rr_arbiter: token round-robin flit arbiter feeding one registered output flit.
// Define TOKEN_ARB_LOCK_EN to hold the grant from a packet head through its in_last tail.
module token_rr_arbiter #(
   parameter int NPORT = 4,
   parameter int WIDTH = 8,
   parameter int INIT_OWNER = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORT-1:0]         in_valid,
   input  logic [NPORT*WIDTH-1:0]   in_data,
   input  logic [NPORT-1:0]         in_last,
   output logic [NPORT-1:0]         in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_last,
   input  logic                     out_ready,
   output logic [$clog2(NPORT)-1:0] grant_id
);
   localparam int IW = $clog2(NPORT);
   localparam logic [IW-1:0] INIT = IW'(INIT_OWNER);
   localparam logic [IW-1:0] TOP = IW'(NPORT - 1);

   logic [IW-1:0] token, sel, nxt;
   logic found, load_en, acc, tok_adv;

`ifdef TOKEN_ARB_LOCK_EN
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state, state_d;
   logic locked;
   logic [IW-1:0] owner;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_d;

   always_comb state_d = acc ? (in_last[sel] ? IDLE : LOCKED) : state;

   always_comb begin
      locked = state == LOCKED;
      tok_adv = acc && in_last[sel];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) owner <= INIT;
      else if (acc) owner <= sel;
`else
   always_comb tok_adv = acc;
`endif

   always_comb begin
      int idx;
      found = 1'b0;
      sel = token;
      idx = 0;
      for (int k = 0; k < NPORT; k++) begin
         idx = int'(token) + k;
         idx = idx >= NPORT ? idx - NPORT : idx;
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            sel = IW'(idx);
         end
      end
`ifdef TOKEN_ARB_LOCK_EN
      // a locked owner keeps the output even while it bubbles
      if (locked) begin
         sel = owner;
         found = in_valid[owner];
      end
`endif
   end

   always_comb begin
      load_en = !out_valid || out_ready;
      acc = !rst && load_en && found;
      in_ready = acc ? NPORT'(1) << sel : '0;
      nxt = sel == TOP ? '0 : sel + 1'b1;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         token <= INIT;
         out_valid <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
         grant_id <= INIT;
      end else begin
         if (tok_adv) token <= nxt;
         if (acc) begin
            out_valid <= 1'b1;
            out_data <= in_data[sel*WIDTH +: WIDTH];
            out_last <= in_last[sel];
            grant_id <= sel;
         end else if (load_en) out_valid <= 1'b0;
      end
endmodule
